// File: rtl/paint_framebuffer_if.sv
// Request/response bundle between the paint framebuffer, its brush/clear
// controller and the display read port.
interface paint_framebuffer_if;
    logic [14:0] rd_addr;
    logic [11:0] rd_colour;
    logic [7:0]  cur_x;
    logic [6:0]  cur_y;
    logic [2:0]  brush_size;
    logic [11:0] paint_colour;
    logic        paint_req;
    logic        clear_req;
    logic [11:0] clear_colour;
    logic        busy;
    logic        done;

    modport master (
        output rd_addr, cur_x, cur_y, brush_size, paint_colour,
               paint_req, clear_req, clear_colour,
        input  rd_colour, busy, done
    );

    modport slave (
        input  rd_addr, cur_x, cur_y, brush_size, paint_colour,
               paint_req, clear_req, clear_colour,
        output rd_colour, busy, done
    );
endinterface

// File: rtl/paint_framebuffer.sv
// 160x120x12 framebuffer with a registered display read port and a
// one-pixel-per-clock brush stamp / full-clear write engine.
module paint_framebuffer #(
    parameter int FB_W      = 160,
    parameter int FB_H      = 120,
    parameter int MAX_BRUSH = 8
) (
    input  logic               clk,
    input  logic               reset,
    paint_framebuffer_if.slave fb
);
    localparam int          BW       = $clog2(MAX_BRUSH);
    localparam int          FB_WORDS = FB_W * FB_H;
    localparam logic [8:0]  FB_W9    = 9'(FB_W);
    localparam logic [7:0]  FB_H8    = 8'(FB_H);
    localparam logic [14:0] FB_W15   = 15'(FB_W);
    localparam logic [14:0] FB_SIZE  = 15'(FB_WORDS);
    localparam logic [14:0] FB_LAST  = 15'(FB_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BRUSH = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    logic [11:0]   mem_r [0:FB_WORDS-1];
    state_t        state_r;
    logic [BW-1:0] dx_r;
    logic [BW-1:0] dy_r;
    logic [BW-1:0] n_r;
    logic [7:0]    x0_r;
    logic [6:0]    y0_r;
    logic [11:0]   colour_r;
    logic [14:0]   clr_addr_r;
    logic          busy_r;
    logic          done_r;
    logic [11:0]   rd_colour_r;

    logic [8:0]    px_s;
    logic [7:0]    py_s;
    logic          we_s;
    logic [14:0]   waddr_s;
    logic [11:0]   wdata_s;

    // Widened coordinates so the bounds test sees overflow instead of wrap.
    assign px_s = {1'b0, x0_r} + 9'(dx_r);
    assign py_s = {1'b0, y0_r} + 8'(dy_r);

    // Write port decode: brush pixels outside the frame still take their cycle.
    always_comb begin
        we_s    = 1'b0;
        waddr_s = 15'd0;
        wdata_s = colour_r;
        case (state_r)
            ST_BRUSH: begin
                if ((px_s < FB_W9) && (py_s < FB_H8)) begin
                    we_s    = 1'b1;
                    waddr_s = 15'(py_s) * FB_W15 + 15'(px_s);
                end else begin
                    we_s    = 1'b0;
                end
            end
            ST_CLEAR: begin
                we_s    = 1'b1;
                waddr_s = clr_addr_r;
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
    end

    // Memory write; reset only suppresses the write, contents persist.
    always_ff @(posedge clk) begin
        if (we_s && !reset) begin
            mem_r[waddr_s] <= wdata_s;
        end
    end

    // Registered read port, old data on read/write collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_colour_r <= 12'd0;
        end else if (fb.rd_addr < FB_SIZE) begin
            rd_colour_r <= mem_r[fb.rd_addr];
        end else begin
            rd_colour_r <= 12'd0;
        end
    end

    // Control FSM with latched operands and registered busy/done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            dx_r       <= BW'(0);
            dy_r       <= BW'(0);
            n_r        <= BW'(0);
            x0_r       <= 8'd0;
            y0_r       <= 7'd0;
            colour_r   <= 12'd0;
            clr_addr_r <= 15'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    dx_r       <= BW'(0);
                    dy_r       <= BW'(0);
                    clr_addr_r <= 15'd0;
                    if (fb.clear_req) begin
                        colour_r <= fb.clear_colour;
                        busy_r   <= 1'b1;
                        state_r  <= ST_CLEAR;
                    end else if (fb.paint_req) begin
                        x0_r     <= fb.cur_x;
                        y0_r     <= fb.cur_y;
                        n_r      <= BW'(fb.brush_size);
                        colour_r <= fb.paint_colour;
                        busy_r   <= 1'b1;
                        state_r  <= ST_BRUSH;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_BRUSH: begin
                    if (dx_r == n_r) begin
                        dx_r <= BW'(0);
                        if (dy_r == n_r) begin
                            dy_r    <= BW'(0);
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_IDLE;
                        end else begin
                            dy_r <= dy_r + BW'(1);
                        end
                    end else begin
                        dx_r <= dx_r + BW'(1);
                    end
                end
                ST_CLEAR: begin
                    if (clr_addr_r == FB_LAST) begin
                        clr_addr_r <= 15'd0;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        state_r    <= ST_IDLE;
                    end else begin
                        clr_addr_r <= clr_addr_r + 15'd1;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign fb.rd_colour = rd_colour_r;
    assign fb.busy      = busy_r;
    assign fb.done      = done_r;
endmodule

// File: tb/tb_paint_framebuffer.sv
// Directed self-checking bench for paint_framebuffer: reset, clear, brush,
// edge clipping, back-to-back requests, clear priority and mid-op reset.
module tb_paint_framebuffer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    paint_framebuffer_if fb();

    paint_framebuffer dut (
        .clk   (clk),
        .reset (reset),
        .fb    (fb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic read_px(input logic [14:0] addr, output logic [11:0] data);
        fb.rd_addr = addr;
        @(posedge clk);
        #1;
        data = fb.rd_colour;
    endtask

    task automatic pulse_paint(input logic [7:0] x, input logic [6:0] y,
                               input logic [2:0] sz, input logic [11:0] col);
        fb.cur_x        = x;
        fb.cur_y        = y;
        fb.brush_size   = sz;
        fb.paint_colour = col;
        fb.paint_req    = 1'b1;
        @(posedge clk);
        #1;
        fb.paint_req    = 1'b0;
    endtask

    task automatic pulse_clear(input logic [11:0] col);
        fb.clear_colour = col;
        fb.clear_req    = 1'b1;
        @(posedge clk);
        #1;
        fb.clear_req    = 1'b0;
    endtask

    // Counts edges until busy drops (bounded) and the done pulses seen.
    task automatic run_op(output int cycles, output int dones);
        cycles = 0;
        dones  = 0;
        while (fb.busy === 1'b1 && cycles < 20000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (fb.done === 1'b1) dones++;
        end
    endtask

    task automatic test_reset();
        logic [11:0] d;
        reset = 1'b1;
        fb.rd_addr = 15'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (fb.rd_colour !== 12'h000) begin failures++; $display("FAIL reset_rd_colour got=%h exp=000", fb.rd_colour); end
        checks++;
        if (fb.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", fb.busy); end
        checks++;
        if (fb.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", fb.done); end
        reset = 1'b0;
        read_px(15'd19200, d);
        checks++;
        if (d !== 12'h000) begin failures++; $display("FAIL reset_oob_read got=%h exp=000", d); end
    endtask

    task automatic test_clear();
        int cyc, dn, bad;
        logic [11:0] d;
        pulse_clear(12'hF00);
        checks++;
        if (fb.busy !== 1'b1) begin failures++; $display("FAIL clear_busy_start got=%b exp=1", fb.busy); end
        run_op(cyc, dn);
        checks++;
        if (cyc !== 19200) begin failures++; $display("FAIL clear_cycles got=%0d exp=19200", cyc); end
        checks++;
        if (dn !== 1) begin failures++; $display("FAIL clear_done_count got=%0d exp=1", dn); end
        @(posedge clk);
        #1;
        checks++;
        if (fb.done !== 1'b0) begin failures++; $display("FAIL clear_done_width got=%b exp=0", fb.done); end
        bad = 0;
        for (int a = 0; a < 19200; a++) begin
            read_px(15'(a), d);
            if (d !== 12'hF00) begin
                if (bad < 4) $display("FAIL clear_sweep addr=%0d got=%h exp=F00", a, d);
                bad++;
            end
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL clear_sweep_total bad=%0d exp=0", bad); end
        read_px(15'd19200, d);
        checks++;
        if (d !== 12'h000) begin failures++; $display("FAIL clear_oob_19200 got=%h exp=000", d); end
        read_px(15'd32767, d);
        checks++;
        if (d !== 12'h000) begin failures++; $display("FAIL clear_oob_max got=%h exp=000", d); end
    endtask

    task automatic test_brush();
        int cyc, dn;
        logic [11:0] d;
        logic [14:0] rows [3];
        rows[0] = 15'd810;
        rows[1] = 15'd970;
        rows[2] = 15'd1130;
        pulse_paint(8'd10, 7'd5, 3'd2, 12'h0F0);
        run_op(cyc, dn);
        checks++;
        if (cyc !== 9) begin failures++; $display("FAIL brush_cycles got=%0d exp=9", cyc); end
        checks++;
        if (dn !== 1) begin failures++; $display("FAIL brush_done_count got=%0d exp=1", dn); end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                read_px(rows[r] + 15'(c), d);
                checks++;
                if (d !== 12'h0F0) begin failures++; $display("FAIL brush_px addr=%0d got=%h exp=0F0", rows[r] + 15'(c), d); end
            end
        end
        read_px(15'd809, d);
        checks++;
        if (d !== 12'hF00) begin failures++; $display("FAIL brush_left_edge got=%h exp=F00", d); end
        read_px(15'd813, d);
        checks++;
        if (d !== 12'hF00) begin failures++; $display("FAIL brush_right_edge got=%h exp=F00", d); end
    endtask

    task automatic test_clip();
        int cyc, dn;
        logic [11:0] d;
        pulse_paint(8'd158, 7'd118, 3'd3, 12'h00F);
        run_op(cyc, dn);
        checks++;
        if (cyc !== 16) begin failures++; $display("FAIL clip_cycles got=%0d exp=16", cyc); end
        checks++;
        if (dn !== 1) begin failures++; $display("FAIL clip_done_count got=%0d exp=1", dn); end
        read_px(15'd19038, d);
        checks++;
        if (d !== 12'h00F) begin failures++; $display("FAIL clip_158_118 got=%h exp=00F", d); end
        read_px(15'd19039, d);
        checks++;
        if (d !== 12'h00F) begin failures++; $display("FAIL clip_159_118 got=%h exp=00F", d); end
        read_px(15'd19198, d);
        checks++;
        if (d !== 12'h00F) begin failures++; $display("FAIL clip_158_119 got=%h exp=00F", d); end
        read_px(15'd19199, d);
        checks++;
        if (d !== 12'h00F) begin failures++; $display("FAIL clip_159_119 got=%h exp=00F", d); end
        read_px(15'd0, d);
        checks++;
        if (d !== 12'hF00) begin failures++; $display("FAIL clip_wrap_addr0 got=%h exp=F00", d); end
        read_px(15'd19040, d);
        checks++;
        if (d !== 12'hF00) begin failures++; $display("FAIL clip_row_wrap got=%h exp=F00", d); end
        read_px(15'd19037, d);
        checks++;
        if (d !== 12'hF00) begin failures++; $display("FAIL clip_left_neighbour got=%h exp=F00", d); end
    endtask

    task automatic test_back_to_back();
        int cyc, dn;
        logic [11:0] d;
        pulse_paint(8'd0, 7'd0, 3'd0, 12'h123);
        run_op(cyc, dn);
        checks++;
        if (fb.done !== 1'b1) begin failures++; $display("FAIL b2b_done_now got=%b exp=1", fb.done); end
        pulse_paint(8'd1, 7'd0, 3'd0, 12'h456);
        checks++;
        if (fb.busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", fb.busy); end
        run_op(cyc, dn);
        checks++;
        if (cyc !== 1) begin failures++; $display("FAIL b2b_cycles got=%0d exp=1", cyc); end
        read_px(15'd0, d);
        checks++;
        if (d !== 12'h123) begin failures++; $display("FAIL b2b_px0 got=%h exp=123", d); end
        read_px(15'd1, d);
        checks++;
        if (d !== 12'h456) begin failures++; $display("FAIL b2b_px1 got=%h exp=456", d); end
    endtask

    task automatic test_priority();
        int cyc, dn;
        logic [11:0] d;
        fb.clear_colour = 12'h0AA;
        fb.clear_req    = 1'b1;
        pulse_paint(8'd20, 7'd20, 3'd1, 12'hFFF);
        fb.clear_req    = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        pulse_paint(8'd30, 7'd30, 3'd0, 12'h0FF);
        run_op(cyc, dn);
        checks++;
        if (cyc + 6 !== 19200) begin failures++; $display("FAIL prio_clear_cycles got=%0d exp=19200", cyc + 6); end
        checks++;
        if (dn !== 1) begin failures++; $display("FAIL prio_done_count got=%0d exp=1", dn); end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (fb.busy !== 1'b0) begin failures++; $display("FAIL prio_dropped_busy got=%b exp=0", fb.busy); end
        read_px(15'd4830, d);
        checks++;
        if (d !== 12'h0AA) begin failures++; $display("FAIL prio_dropped_px got=%h exp=0AA", d); end
        read_px(15'd3220, d);
        checks++;
        if (d !== 12'h0AA) begin failures++; $display("FAIL prio_brush_px got=%h exp=0AA", d); end
        read_px(15'd3381, d);
        checks++;
        if (d !== 12'h0AA) begin failures++; $display("FAIL prio_brush_px2 got=%h exp=0AA", d); end
    endtask

    task automatic test_reset_abort();
        int cyc, dn;
        logic [11:0] d;
        pulse_paint(8'd40, 7'd50, 3'd7, 12'h555);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (fb.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", fb.busy); end
        checks++;
        if (fb.done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", fb.done); end
        read_px(15'd8040, d);
        checks++;
        if (d !== 12'h555) begin failures++; $display("FAIL abort_px1 got=%h exp=555", d); end
        read_px(15'd8043, d);
        checks++;
        if (d !== 12'h555) begin failures++; $display("FAIL abort_px4 got=%h exp=555", d); end
        read_px(15'd8044, d);
        checks++;
        if (d !== 12'h0AA) begin failures++; $display("FAIL abort_px5 got=%h exp=0AA", d); end
        pulse_paint(8'd100, 7'd100, 3'd0, 12'h777);
        run_op(cyc, dn);
        checks++;
        if (cyc !== 1 || dn !== 1) begin failures++; $display("FAIL abort_next_op cycles=%0d dones=%0d exp=1/1", cyc, dn); end
        read_px(15'd16100, d);
        checks++;
        if (d !== 12'h777) begin failures++; $display("FAIL abort_next_px got=%h exp=777", d); end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b1;
        fb.rd_addr      = 15'd0;
        fb.cur_x        = 8'd0;
        fb.cur_y        = 7'd0;
        fb.brush_size   = 3'd0;
        fb.paint_colour = 12'h000;
        fb.paint_req    = 1'b0;
        fb.clear_req    = 1'b0;
        fb.clear_colour = 12'h000;
        test_reset();
        test_clear();
        test_brush();
        test_clip();
        test_back_to_back();
        test_priority();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
